// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 8-bit processor.
//
// Holds the PC, drives the single-port 256x8 RAM (synchronous read, 1-cycle
// latency) and assembles an opcode byte plus an optional operand byte. The
// result goes to decode over a valid/ready handshake. Execute can redirect the
// PC, and fetch can be stalled while waiting to issue an opcode read.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   ram_address         RAM address, always the current PC
//   ram_wren, ram_data  tied off; fetch never writes
//   ram_q               RAM read data for the address presented last cycle
//   instr_valid/ready   handshake to decode
//   instr_opcode        opcode byte
//   instr_operand       operand byte (8'h00 for one-byte instructions)
//   instr_len2          1 = two-byte instruction
//   instr_pc            address of the opcode byte
//   pc_load, pc_target  redirect request from execute
//   stall               hold fetch in the opcode-issue state
//   fetch_count         (FETCH_PERF_EN) accepted instructions, saturating
//   stall_count         (FETCH_PERF_EN) stalled opcode-issue cycles, saturating
//
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.

module fetch_unit #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter logic [15:0] OPERAND_MAP = 16'hC80C
) (
  input  logic        clock,
  input  logic        reset,
  output logic [7:0]  ram_address,
  output logic        ram_wren,
  output logic [7:0]  ram_data,
  input  logic [7:0]  ram_q,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_operand,
  output logic        instr_len2,
  output logic [7:0]  instr_pc,
  input  logic        pc_load,
  input  logic [7:0]  pc_target,
  input  logic        stall
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    StFOp,
    StCapOp,
    StCapOpr,
    StValid
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic       len2_q, len2_d;
  logic [7:0] ipc_q, ipc_d;
  logic       is_two;

  // Only opcodes 00..0F can carry an operand; the map selects which do.
  assign is_two = (ram_q[7:4] == 4'h0) && OPERAND_MAP[ram_q[3:0]];

  assign ram_address   = pc_q;
  assign ram_wren      = 1'b0;
  assign ram_data      = 8'h00;
  assign instr_valid   = (state_q == StValid);
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_len2    = len2_q;
  assign instr_pc      = ipc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len2_d    = len2_q;
    ipc_d     = ipc_q;

    unique case (state_q)
      StFOp: begin
        if (!stall) begin
          pc_d    = pc_q + 8'd1;
          ipc_d   = pc_q;
          state_d = StCapOp;
        end
      end
      StCapOp: begin
        opcode_d = ram_q;
        if (is_two) begin
          pc_d    = pc_q + 8'd1;
          len2_d  = 1'b1;
          state_d = StCapOpr;
        end else begin
          operand_d = 8'h00;
          len2_d    = 1'b0;
          state_d   = StValid;
        end
      end
      StCapOpr: begin
        operand_d = ram_q;
        state_d   = StValid;
      end
      StValid: begin
        if (instr_ready) begin
          state_d = StFOp;
        end
      end
      default: state_d = StFOp;
    endcase

    // Redirect overrides everything; partially fetched bytes are abandoned.
    if (pc_load) begin
      pc_d    = pc_target;
      state_d = StFOp;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFOp;
      pc_q      <= RESET_PC;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      len2_q    <= 1'b0;
      ipc_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len2_q    <= len2_d;
      ipc_q     <= ipc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      if (instr_valid && instr_ready && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if ((state_q == StFOp) && stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
